// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - RV32I instruction word encoder with two-word LI expansion
// Encodes one request per cycle into a registered word stream; LI may emit LUI then ADDI.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  typedef enum logic [1:0] {IDLE, HOLD, HOLD2} state_t;

  localparam logic [2:0] F_I  = 3'd0;
  localparam logic [2:0] F_S  = 3'd1;
  localparam logic [2:0] F_B  = 3'd2;
  localparam logic [2:0] F_J  = 3'd3;
  localparam logic [2:0] F_U  = 3'd4;
  localparam logic [2:0] F_LI = 3'd5;

  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_LUI  = 7'h37;

  state_t state, state_nx;

  logic signed [31:0] simm;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic [31:0] enc_word, enc_pend, pend;
  logic        enc_err, enc_two;
  logic        accept, consume, load_enc, load_pend;

  assign simm  = $signed(in_imm);
  // (imm + 0x800) >> 12 without carrying the unused low bits around
  assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};
  assign li_lo = in_imm[11:0];

  always_comb begin
    enc_word = 32'd0;
    enc_pend = 32'd0;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    case (in_fmt)
      F_I: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      F_S: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      F_B: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
      end
      F_J: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
      end
      F_U: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = (in_imm[11:0] != 12'd0);
      end
      F_LI: begin
        if (li_hi == 20'd0) begin
          enc_word = {li_lo, 5'd0, 3'b000, in_rd, OP_ADDI};
        end else if (li_lo == 12'd0) begin
          enc_word = {li_hi, in_rd, OP_LUI};
        end else begin
          enc_word = {li_hi, in_rd, OP_LUI};
          enc_pend = {li_lo, in_rd, 3'b000, in_rd, OP_ADDI};
          enc_two  = 1'b1;
        end
      end
      default: begin
        enc_word = 32'd0;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign in_ready  = rst_n && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign out_valid = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_nx  = state;
    load_enc  = 1'b0;
    load_pend = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          load_enc = 1'b1;
          state_nx = enc_two ? HOLD2 : HOLD;
        end else if (consume) begin
          state_nx = IDLE;
        end
      end
      HOLD2: begin
        if (consume) begin
          load_pend = 1'b1;
          state_nx  = HOLD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_instr <= 32'd0;
      out_err   <= 1'b0;
      out_last  <= 1'b0;
      pend      <= 32'd0;
    end else begin
      state <= state_nx;
      if (load_enc) begin
        out_instr <= enc_word;
        out_err   <= enc_err;
        out_last  <= !enc_two;
        pend      <= enc_pend;
      end else if (load_pend) begin
        out_instr <= pend;
        out_err   <= 1'b0;
        out_last  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed self-checking bench for imm_encoder
// Inputs change and outputs are sampled on the falling clock edge.
module tb_imm_encoder;

  localparam logic [2:0] F_I  = 3'd0;
  localparam logic [2:0] F_S  = 3'd1;
  localparam logic [2:0] F_B  = 3'd2;
  localparam logic [2:0] F_J  = 3'd3;
  localparam logic [2:0] F_U  = 3'd4;
  localparam logic [2:0] F_LI = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  int n_cmp = 0;
  int n_bad = 0;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_funct3 = f3;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  task automatic single(input string tag, input logic [2:0] f, input logic [6:0] op,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_instr, input logic exp_err);
    drive(f, op, f3, rd, rs1, rs2, imm);
    #1 chk({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".instr"}, out_instr, exp_instr);
    chk({tag, ".err"}, out_err, exp_err);
    chk({tag, ".last"}, out_last, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(F_I, 7'h0, 3'h0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.instr", out_instr, 0);
    chk("rst.err", out_err, 0);
    chk("rst.last", out_last, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("idle.in_ready", in_ready, 1);
    @(negedge clk);

    single("i_neg1",   F_I, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF10093, 0);
    single("s_neg4",   F_S, 7'h23, 3'd2, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC, 32'hFE312E23, 0);
    single("i_2048",   F_I, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'd2048,      32'h80010093, 1);
    single("b_3",      F_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3,         32'h00208163, 1);
    single("b_4096",   F_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd4096,      32'h80208063, 1);
    single("b_neg2",   F_B, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFE, 32'hFE208FE3, 0);
    single("j_2048",   F_J, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048,      32'h001000EF, 0);
    single("j_2p20",   F_J, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h800000EF, 1);
    single("u_ok",     F_U, 7'h37, 3'd0, 5'd2, 5'd0, 5'd0, 32'hABCD_E000, 32'hABCDE137, 0);
    single("u_low",    F_U, 7'h37, 3'd0, 5'd2, 5'd0, 5'd0, 32'h0000_1001, 32'h00001137, 1);
    single("rsvd6",    3'd6, 7'h13, 3'd0, 5'd1, 5'd2, 5'd3, 32'd5,        32'h00000000, 1);
    single("li_7ff",   F_LI, 7'h7F, 3'd7, 5'd1, 5'd31, 5'd31, 32'h0000_07FF, 32'h7FF00093, 0);
    single("li_1000",  F_LI, 7'h7F, 3'd7, 5'd1, 5'd31, 5'd31, 32'h0000_1000, 32'h000010B7, 0);

    // two-word LI with the LUI back-pressured for two cycles
    drive(F_LI, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("li2.lui.valid", out_valid, 1);
    chk("li2.lui.instr", out_instr, 32'h123462B7);
    chk("li2.lui.last", out_last, 0);
    chk("li2.lui.err", out_err, 0);
    chk("li2.lui.in_ready", in_ready, 0);
    @(negedge clk);
    chk("li2.lui.stable", out_instr, 32'h123462B7);
    chk("li2.lui.in_ready_stall", in_ready, 0);
    out_ready = 1'b1;
    #1 chk("li2.hold2.in_ready", in_ready, 0);
    @(negedge clk);
    chk("li2.addi.valid", out_valid, 1);
    chk("li2.addi.instr", out_instr, 32'hFFF28293);
    chk("li2.addi.last", out_last, 1);
    chk("li2.addi.err", out_err, 0);

    // stall five cycles with a word held and the next request waiting
    drive(F_I, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'h010);
    @(negedge clk);
    drive(F_I, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'h020);
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall.instr", out_instr, 32'h01000093);
      chk("stall.valid", out_valid, 1);
      chk("stall.in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("stall.release.in_ready", in_ready, 1);
    @(negedge clk);
    chk("b2b.w2", out_instr, 32'h02000113);
    drive(F_I, 7'h13, 3'd0, 5'd3, 5'd0, 5'd0, 32'h030);
    @(negedge clk);
    chk("b2b.w3", out_instr, 32'h03000193);
    chk("b2b.w3.valid", out_valid, 1);
    drive(F_I, 7'h13, 3'd0, 5'd4, 5'd0, 5'd0, 32'h040);
    @(negedge clk);
    chk("b2b.w4", out_instr, 32'h04000213);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b.drained", out_valid, 0);

    // reset while the LUI is shown and the ADDI is pending
    drive(F_LI, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst2.lui.instr", out_instr, 32'h123462B7);
    chk("rst2.lui.valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2.in_ready", in_ready, 0);
    rst_n = 1'b1;
    chk("rst2.valid", out_valid, 0);
    chk("rst2.instr", out_instr, 0);
    chk("rst2.last", out_last, 0);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst2.no_addi", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, request present.
REQ-004 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready on a clk edge.
REQ-005 SHALL have port in_fmt, input, 3, format select: 0=I, 1=S, 2=B, 3=J, 4=U, 5=LI (32-bit constant load), 6..7 reserved.
REQ-006 SHALL have port in_opcode, input, 7, opcode field [6:0].
REQ-007 SHALL have port in_funct3, input, 3, funct3 field [14:12].
REQ-008 SHALL have port in_rd, input, 5, destination register.
REQ-009 SHALL have port in_rs1, input, 5, source register 1.
REQ-010 SHALL have port in_rs2, input, 5, source register 2.
REQ-011 SHALL have port in_imm, input, 32, signed byte-offset or constant.
REQ-012 SHALL have port out_valid, output, 1, out_instr holds a valid word.
REQ-013 SHALL have port out_ready, input, 1, word consumed when out_valid && out_ready on a clk edge.
REQ-014 SHALL have port out_instr, output, 32, encoded RV32I instruction word.
REQ-015 SHALL have port out_err, output, 1, immediate out of range or misaligned, or fmt reserved; qualified by out_valid.
REQ-016 SHALL have port out_last, output, 1, final word of the current request.

Function
REQ-017 SHALL register every accepted request; the first word is valid the cycle after acceptance (latency 1).
REQ-018 SHALL encode I as {imm[11:0],rs1,funct3,rd,opcode}; err if imm not in -2048..2047.
REQ-019 SHALL encode S as {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; err if imm not in -2048..2047.
REQ-020 SHALL encode B as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; err if imm not in -4096..4094 or imm[0]=1.
REQ-021 SHALL encode J as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; err if imm not in -1048576..1048574 or imm[0]=1.
REQ-022 SHALL encode U as {imm[31:12],rd,opcode}; err if imm[11:0] != 0.
REQ-023 On err, SHALL still emit the word built from truncated fields, out_err=1 and out_last=1.
REQ-024 SHALL, for reserved fmt, emit out_instr=0x00000000, out_err=1 and out_last=1.
REQ-025 SHALL, for LI, ignore in_opcode, in_funct3, in_rs1 and in_rs2, and compute hi=(imm+0x800)[31:12] (mod 2^32) and lo=imm[11:0].
REQ-026 LI SHALL emit exactly one of: hi=0 -> single ADDI rd,x0,lo; hi!=0 and lo=0 -> single LUI rd,hi; otherwise LUI rd,hi (out_last=0) then ADDI rd,rd,lo (out_last=1).
REQ-027 LI SHALL never assert out_err.
REQ-028 SHALL implement states IDLE (no word held), HOLD (one word held, none pending) and HOLD2 (LUI held, ADDI pending).
REQ-029 SHALL transition IDLE->HOLD on a single-word accept and IDLE->HOLD2 on a two-word LI accept.
REQ-030 SHALL transition HOLD2->HOLD when the LUI is consumed, loading the ADDI in the same edge.
REQ-031 SHALL transition HOLD->IDLE when the word is consumed with no accept, and stay in HOLD (or go to HOLD2) when consume and accept coincide.
REQ-032 SHALL drive in_ready = (state==IDLE) || (state==HOLD && out_ready); in_ready SHALL be 0 in HOLD2.
REQ-033 SHALL sustain 1 single-word request per cycle.
REQ-034 SHALL hold out_instr, out_err and out_last stable while out_valid=1 and out_ready=0.

Reset
REQ-035 While rst_n=0 at a clk edge, SHALL enter IDLE and set out_valid=0, out_instr=0, out_err=0, out_last=0; in_ready SHALL be 0 while rst_n=0.
REQ-036 A reset during HOLD2 SHALL discard both the held LUI and the pending ADDI; no word SHALL appear after reset release without a new accept.

Verification
REQ-037 Bench SHALL cover: I, opcode=0x13, f3=0, rd=1, rs1=2, imm=-1 -> out_instr=0xFFF10093, err=0, last=1, one cycle after accept.
REQ-038 Bench SHALL cover: LI rd=5, imm=0x12345FFF -> 0x123462B7 (last=0), then 0xFFF28293 (last=1); in_ready=0 until the LUI is consumed.
REQ-039 Bench SHALL cover: LI rd=1, imm=0x000007FF -> single 0x7FF00093, last=1; LI rd=1, imm=0x00001000 -> single LUI 0x000010B7.
REQ-040 Bench SHALL cover: B imm=3, and B imm=4096 -> err=1, last=1 on each.
REQ-041 Bench SHALL cover: out_ready=0 for 5 cycles with a word held -> out_instr stable and in_ready=0, then back-to-back accepts at 1 per cycle with no loss or duplication.
REQ-042 Bench SHALL cover: rst_n=0 for one cycle while in HOLD2 (LUI shown) -> out_valid=0 next cycle, and no ADDI emitted afterwards.
